// File: rtl/target_tracker_pkg.sv
// Shared definitions for the target tracker: coordinate width, accumulator
// init constants and FSM state encoding.
package target_tracker_pkg;

  localparam int COORD_W = 11;
  localparam logic [COORD_W-1:0] COORD_MIN_INIT = 11'd2047;
  localparam logic [COORD_W-1:0] COORD_MAX_INIT = 11'd0;

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } state_t;

endpackage

// File: rtl/target_tracker_bbox_accum.sv
// Bounding-box and hit-count accumulator. A hit arriving with clear seeds the
// fresh accumulators instead of being dropped.
module bbox_accum
  import target_tracker_pkg::*;
#(
  parameter int CNT_W = 20
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               hit,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic [COORD_W-1:0] xmin,
  output logic [COORD_W-1:0] xmax,
  output logic [COORD_W-1:0] ymin,
  output logic [COORD_W-1:0] ymax,
  output logic [CNT_W-1:0]   count
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      xmin  <= COORD_MIN_INIT;
      xmax  <= COORD_MAX_INIT;
      ymin  <= COORD_MIN_INIT;
      ymax  <= COORD_MAX_INIT;
      count <= '0;
    end else if (clear) begin
      if (hit) begin
        xmin  <= x;
        xmax  <= x;
        ymin  <= y;
        ymax  <= y;
        count <= CNT_W'(1);
      end else begin
        xmin  <= COORD_MIN_INIT;
        xmax  <= COORD_MAX_INIT;
        ymin  <= COORD_MIN_INIT;
        ymax  <= COORD_MAX_INIT;
        count <= '0;
      end
    end else if (hit) begin
      if (x < xmin) xmin <= x;
      if (x > xmax) xmax <= x;
      if (y < ymin) ymin <= y;
      if (y > ymax) ymax <= y;
      if (count != '1) count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/target_tracker.sv
// Per-frame target tracker: snapshots the bounding box on new_frame and
// reports it over a valid/ready handshake. Optional ovr_cnt: TARGET_TRACKER_OVR_CNT_EN.
//
// state  | meaning
// WAIT   | idle after reset, pixels ignored until the first new_frame
// ACCUM  | accumulating hits of the current frame
// REPORT | one cycle: load result from the snapshot, accumulation continues
module target_tracker
  import target_tracker_pkg::*;
#(
  parameter int MIN_HITS = 16,
  parameter int CNT_W    = 20
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               pix_valid,
  input  logic               pix_hit,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic               new_frame,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_found,
  output logic [COORD_W-1:0] res_xmin,
  output logic [COORD_W-1:0] res_xmax,
  output logic [COORD_W-1:0] res_ymin,
  output logic [COORD_W-1:0] res_ymax,
  output logic [COORD_W-1:0] res_cx,
  output logic [COORD_W-1:0] res_cy,
  output logic [CNT_W-1:0]   res_hits,
`ifdef TARGET_TRACKER_OVR_CNT_EN
  output logic [7:0]         ovr_cnt,
`endif
  output logic               overrun
);

  state_t state_q, state_d;

  logic               acc_hit, snap_en, overwrite;
  logic [COORD_W-1:0] acc_xmin, acc_xmax, acc_ymin, acc_ymax;
  logic [CNT_W-1:0]   acc_cnt;
  logic [COORD_W-1:0] snap_xmin, snap_xmax, snap_ymin, snap_ymax;
  logic [CNT_W-1:0]   snap_cnt;
  logic [COORD_W:0]   sum_x, sum_y;
  logic               found_calc;

  // A hit on the new_frame cycle opens the new frame, even out of WAIT.
  assign acc_hit = pix_valid & pix_hit & ((state_q != WAIT) | new_frame);
  assign snap_en = new_frame & (state_q != WAIT);

  bbox_accum #(.CNT_W(CNT_W)) u_accum (
    .clock (clock),
    .reset (reset),
    .clear (new_frame),
    .hit   (acc_hit),
    .x     (pix_x),
    .y     (pix_y),
    .xmin  (acc_xmin),
    .xmax  (acc_xmax),
    .ymin  (acc_ymin),
    .ymax  (acc_ymax),
    .count (acc_cnt)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= WAIT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT:    if (new_frame) state_d = ACCUM;
      ACCUM:   if (new_frame) state_d = REPORT;
      REPORT:  state_d = new_frame ? REPORT : ACCUM;
      default: state_d = WAIT;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      snap_xmin <= COORD_MIN_INIT;
      snap_xmax <= COORD_MAX_INIT;
      snap_ymin <= COORD_MIN_INIT;
      snap_ymax <= COORD_MAX_INIT;
      snap_cnt  <= '0;
    end else if (snap_en) begin
      snap_xmin <= acc_xmin;
      snap_xmax <= acc_xmax;
      snap_ymin <= acc_ymin;
      snap_ymax <= acc_ymax;
      snap_cnt  <= acc_cnt;
    end
  end

  assign sum_x      = {1'b0, snap_xmin} + {1'b0, snap_xmax};
  assign sum_y      = {1'b0, snap_ymin} + {1'b0, snap_ymax};
  assign found_calc = (snap_cnt >= CNT_W'(MIN_HITS));
  assign overwrite  = (state_q == REPORT) & res_valid & ~res_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      res_valid <= 1'b0;
      res_found <= 1'b0;
      res_xmin  <= '0;
      res_xmax  <= '0;
      res_ymin  <= '0;
      res_ymax  <= '0;
      res_cx    <= '0;
      res_cy    <= '0;
      res_hits  <= '0;
      overrun   <= 1'b0;
    end else if (state_q == REPORT) begin
      res_valid <= 1'b1;
      res_found <= found_calc;
      res_xmin  <= found_calc ? snap_xmin : '0;
      res_xmax  <= found_calc ? snap_xmax : '0;
      res_ymin  <= found_calc ? snap_ymin : '0;
      res_ymax  <= found_calc ? snap_ymax : '0;
      res_cx    <= found_calc ? sum_x[COORD_W:1] : '0;
      res_cy    <= found_calc ? sum_y[COORD_W:1] : '0;
      res_hits  <= snap_cnt;
      if (overwrite) overrun <= 1'b1;
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

`ifdef TARGET_TRACKER_OVR_CNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                         ovr_cnt <= '0;
    else if (overwrite && ovr_cnt != 8'hFF) ovr_cnt <= ovr_cnt + 8'd1;
  end
`endif

endmodule
